// File: rtl/led_driver_rx.sv
// ---------------------------------------------------------------------------
// led_driver_rx
// Receive-side model of the LED driver serial port. SCLK, SIN and LAT are
// oversampled in the clk domain and decoded back into grayscale-latch writes
// and function-control writes. The number of SCLK rises seen while LAT is
// high selects the command when LAT falls.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-low
//   SCLK      serial clock (same clock domain as clk)
//   SIN       serial data, MSB first
//   LAT       latch / command line
//   gs_wr     one-cycle pulse: grayscale word written
//   gs_index  index of the word written by gs_wr
//   gs_data   word written by gs_wr
//   latgs     one-cycle pulse: grayscale latch transfer
//   fc_wr     one-cycle pulse: function-control register updated
//   fc_data   function-control register
//   cmd_err   one-cycle pulse: unknown or refused command
//   len_err   one-cycle pulse: data command with wrong bit count
// ---------------------------------------------------------------------------
module led_driver_rx #(
   parameter int SHIFT_WIDTH       = 48,
   parameter int NB_LEDS_PER_GROUP = 16,
   parameter int LAT_CNT_WIDTH     = 5
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 SCLK,
   input  logic                                 SIN,
   input  logic                                 LAT,
   output logic                                 gs_wr,
   output logic [$clog2(NB_LEDS_PER_GROUP)-1:0] gs_index,
   output logic [SHIFT_WIDTH-1:0]               gs_data,
   output logic                                 latgs,
   output logic                                 fc_wr,
   output logic [SHIFT_WIDTH-1:0]               fc_data,
   output logic                                 cmd_err,
   output logic                                 len_err
);

   localparam int IDX_W     = $clog2(NB_LEDS_PER_GROUP);
   localparam int BIT_CNT_W = $clog2(2 * SHIFT_WIDTH + 1);
   localparam logic [BIT_CNT_W-1:0] BIT_MAX  = BIT_CNT_W'(2 * SHIFT_WIDTH);
   localparam logic [BIT_CNT_W-1:0] BIT_GOOD = BIT_CNT_W'(SHIFT_WIDTH);

   // Command codes, expressed as LAT-high SCLK counts
   localparam logic [LAT_CNT_WIDTH-1:0] CMD_WRTGS   = LAT_CNT_WIDTH'(1);
   localparam logic [LAT_CNT_WIDTH-1:0] CMD_LATGS   = LAT_CNT_WIDTH'(3);
   localparam logic [LAT_CNT_WIDTH-1:0] CMD_WRTFC   = LAT_CNT_WIDTH'(5);
   localparam logic [LAT_CNT_WIDTH-1:0] CMD_FCWRTEN = LAT_CNT_WIDTH'(15);

   // Input samplers plus one extra stage on SCLK/LAT for edge detection.
   // SCLK and LAT come from clk, so a single stage is enough.
   logic sclk_q, sin_q, lat_q, sclk_prev_q, lat_prev_q;

   logic [SHIFT_WIDTH-1:0]   shreg_q,    shreg_d;
   logic [BIT_CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
   logic [LAT_CNT_WIDTH-1:0] lat_cnt_q,  lat_cnt_d;
   logic [IDX_W-1:0]         word_idx_q, word_idx_d;
   logic                     fc_armed_q, fc_armed_d;

   logic                     gs_wr_q,    gs_wr_d;
   logic [IDX_W-1:0]         gs_index_q, gs_index_d;
   logic [SHIFT_WIDTH-1:0]   gs_data_q,  gs_data_d;
   logic                     latgs_q,    latgs_d;
   logic                     fc_wr_q,    fc_wr_d;
   logic [SHIFT_WIDTH-1:0]   fc_data_q,  fc_data_d;
   logic                     cmd_err_q,  cmd_err_d;
   logic                     len_err_q,  len_err_d;

   logic sclk_rise, lat_fall, len_bad;

   // Samplers reset to 0 so an input already high at reset release
   // is treated as a fresh rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_q      <= 1'b0;
         sin_q       <= 1'b0;
         lat_q       <= 1'b0;
         sclk_prev_q <= 1'b0;
         lat_prev_q  <= 1'b0;
      end else begin
         sclk_q      <= SCLK;
         sin_q       <= SIN;
         lat_q       <= LAT;
         sclk_prev_q <= sclk_q;
         lat_prev_q  <= lat_q;
      end
   end

   assign sclk_rise = sclk_q & ~sclk_prev_q;
   assign lat_fall  = ~lat_q & lat_prev_q;

   // Shift/count on SCLK rise, then decode on LAT fall. A shift that lands
   // in the same cycle as the LAT fall still belongs to the word being
   // decoded, so the decode looks at the post-shift values.
   always_comb begin
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      word_idx_d = word_idx_q;
      fc_armed_d = fc_armed_q;
      gs_wr_d    = 1'b0;
      gs_index_d = gs_index_q;
      gs_data_d  = gs_data_q;
      latgs_d    = 1'b0;
      fc_wr_d    = 1'b0;
      fc_data_d  = fc_data_q;
      cmd_err_d  = 1'b0;
      len_err_d  = 1'b0;

      if (sclk_rise) begin
         shreg_d = {shreg_q[SHIFT_WIDTH-2:0], sin_q};
         if (bit_cnt_q != BIT_MAX)
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
         if (lat_q && (lat_cnt_q != '1))
            lat_cnt_d = lat_cnt_q + LAT_CNT_WIDTH'(1);
      end

      len_bad = (bit_cnt_d != BIT_GOOD);

      if (lat_fall) begin
         fc_armed_d = 1'b0;
         unique case (lat_cnt_q)
            CMD_WRTGS: begin
               gs_wr_d    = 1'b1;
               gs_index_d = word_idx_q;
               gs_data_d  = shreg_d;
               word_idx_d = word_idx_q + IDX_W'(1);
               len_err_d  = len_bad;
            end
            CMD_LATGS: begin
               gs_wr_d    = 1'b1;
               latgs_d    = 1'b1;
               gs_index_d = word_idx_q;
               gs_data_d  = shreg_d;
               word_idx_d = '0;
               len_err_d  = len_bad;
            end
            CMD_WRTFC: begin
               if (fc_armed_q) begin
                  fc_wr_d   = 1'b1;
                  fc_data_d = shreg_d;
               end else begin
                  cmd_err_d = 1'b1;
               end
               len_err_d = len_bad;
            end
            CMD_FCWRTEN: begin
               fc_armed_d = 1'b1;
            end
            default: begin
               cmd_err_d = 1'b1;
            end
         endcase
         bit_cnt_d = '0;
         lat_cnt_d = '0;
      end
   end

   // Decoder state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         lat_cnt_q  <= '0;
         word_idx_q <= '0;
         fc_armed_q <= 1'b0;
         gs_wr_q    <= 1'b0;
         gs_index_q <= '0;
         gs_data_q  <= '0;
         latgs_q    <= 1'b0;
         fc_wr_q    <= 1'b0;
         fc_data_q  <= '0;
         cmd_err_q  <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         word_idx_q <= word_idx_d;
         fc_armed_q <= fc_armed_d;
         gs_wr_q    <= gs_wr_d;
         gs_index_q <= gs_index_d;
         gs_data_q  <= gs_data_d;
         latgs_q    <= latgs_d;
         fc_wr_q    <= fc_wr_d;
         fc_data_q  <= fc_data_d;
         cmd_err_q  <= cmd_err_d;
         len_err_q  <= len_err_d;
      end
   end

   assign gs_wr    = gs_wr_q;
   assign gs_index = gs_index_q;
   assign gs_data  = gs_data_q;
   assign latgs    = latgs_q;
   assign fc_wr    = fc_wr_q;
   assign fc_data  = fc_data_q;
   assign cmd_err  = cmd_err_q;
   assign len_err  = len_err_q;

endmodule

// File: tb/tb_led_driver_rx.sv
// ---------------------------------------------------------------------------
// tb_led_driver_rx
// Self-checking bench for led_driver_rx. Commands are built as serial words
// and the expected responses come from a small command-level model of the
// receiver (word index, FC arm flag, held output registers).
// ---------------------------------------------------------------------------
module tb_led_driver_rx;

   localparam int SW = 48;
   localparam int NB = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          SCLK;
   logic          SIN;
   logic          LAT;
   logic          gs_wr;
   logic [3:0]    gs_index;
   logic [SW-1:0] gs_data;
   logic          latgs;
   logic          fc_wr;
   logic [SW-1:0] fc_data;
   logic          cmd_err;
   logic          len_err;

   led_driver_rx #(
      .SHIFT_WIDTH(SW),
      .NB_LEDS_PER_GROUP(NB),
      .LAT_CNT_WIDTH(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .SCLK(SCLK),
      .SIN(SIN),
      .LAT(LAT),
      .gs_wr(gs_wr),
      .gs_index(gs_index),
      .gs_data(gs_data),
      .latgs(latgs),
      .fc_wr(fc_wr),
      .fc_data(fc_data),
      .cmd_err(cmd_err),
      .len_err(len_err)
   );

   // 100 MHz system clock
   always #5 clk = ~clk;

   int nChecks = 0;
   int nErrors = 0;

   // Command-level reference model
   logic [SW-1:0] mShreg;
   logic [SW-1:0] mGsData;
   logic [SW-1:0] mFcData;
   int            mWordIdx;
   int            mGsIndex;
   bit            mFcArmed;

   // Pulse outputs packed as {gs_wr, latgs, fc_wr, cmd_err, len_err}
   logic [4:0] pulses;
   assign pulses = {gs_wr, latgs, fc_wr, cmd_err, len_err};

   // One comparison, counted and reported on failure
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model's current view
   task automatic checkOutput(input string tag, input logic [4:0] expPulse);
      check({tag, " pulses"},   64'(pulses),   64'(expPulse));
      check({tag, " gs_index"}, 64'(gs_index), 64'(mGsIndex));
      check({tag, " gs_data"},  64'(gs_data),  64'(mGsData));
      check({tag, " fc_data"},  64'(fc_data),  64'(mFcData));
   endtask

   task automatic modelReset();
      mShreg   = '0;
      mGsData  = '0;
      mFcData  = '0;
      mWordIdx = 0;
      mGsIndex = 0;
      mFcArmed = 1'b0;
   endtask

   // One serial bit: data and LAT change while SCLK is low, then SCLK pulses
   task automatic shiftBit(input logic b, input logic latHigh);
      @(negedge clk);
      SIN = b;
      LAT = latHigh;
      repeat (2) @(negedge clk);
      SCLK = 1'b1;
      repeat (2) @(negedge clk);
      SCLK = 1'b0;
   endtask

   // Expected response of one command, derived from the command table
   function automatic logic [4:0] modelDecode(input int latClocks, input int nbits);
      logic [4:0] p;
      int latCnt;
      bit lenBad;
      p      = '0;
      latCnt = (latClocks > 31) ? 31 : latClocks;
      lenBad = (((nbits > 2 * SW) ? 2 * SW : nbits) != SW);
      case (latCnt)
         1: begin
            p[4] = 1'b1;
            p[0] = lenBad;
            mGsIndex = mWordIdx;
            mGsData  = mShreg;
            mWordIdx = (mWordIdx + 1) % NB;
            mFcArmed = 1'b0;
         end
         3: begin
            p[4] = 1'b1;
            p[3] = 1'b1;
            p[0] = lenBad;
            mGsIndex = mWordIdx;
            mGsData  = mShreg;
            mWordIdx = 0;
            mFcArmed = 1'b0;
         end
         5: begin
            if (mFcArmed) begin
               p[2] = 1'b1;
               mFcData = mShreg;
            end else begin
               p[1] = 1'b1;
            end
            p[0] = lenBad;
            mFcArmed = 1'b0;
         end
         15: mFcArmed = 1'b1;
         default: begin
            p[1] = 1'b1;
            mFcArmed = 1'b0;
         end
      endcase
      return p;
   endfunction

   // Send one command: the low nbits of data, MSB first, with LAT high on the
   // last latClocks SCLK rises. With coincident set, one extra bit follows and
   // its SCLK rise is sampled in the same cycle as the LAT fall.
   task automatic applyStimulus(input logic [SW-1:0] data, input int nbits,
                                input int latClocks, input bit coincident,
                                input string tag);
      logic [4:0] expPulse;
      logic       b;
      int         total;
      total = coincident ? nbits + 1 : nbits;
      for (int k = 0; k < nbits; k++) begin
         b = data[nbits - 1 - k];
         mShreg = {mShreg[SW-2:0], b};
         shiftBit(b, (k >= nbits - latClocks));
      end
      if (coincident) begin
         b = $urandom_range(1, 0);
         mShreg = {mShreg[SW-2:0], b};
         @(negedge clk);
         SIN = b;
         repeat (2) @(negedge clk);
         SCLK = 1'b1;
         LAT  = 1'b0;
      end else begin
         @(negedge clk);
         LAT = 1'b0;
      end
      expPulse = modelDecode(latClocks, total);
      @(posedge clk); #1;
      check({tag, " early"}, 64'(pulses), 64'(0));
      @(posedge clk); #1;
      checkOutput(tag, expPulse);
      @(posedge clk); #1;
      check({tag, " late"}, 64'(pulses), 64'(0));
      @(negedge clk);
      SCLK = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   logic [SW-1:0] rndData;
   int            latChoices [8] = '{1, 3, 5, 15, 2, 7, 1, 5};
   int            latPick;
   int            bitPick;

   initial begin
      rst  = 1'b0;
      SCLK = 1'b0;
      SIN  = 1'b0;
      LAT  = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset", 5'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] basic WRTGS");
      applyStimulus(48'hA5A5_0F0F_1234, SW, 1, 1'b0, "wrtgs_first");

      $display("[TB] fill group, wrap, latch");
      for (int i = 0; i < NB; i++) begin
         rndData = {16'($urandom), $urandom};
         applyStimulus(rndData, SW, 1, 1'b0, $sformatf("wrtgs_%0d", i));
      end
      rndData = {16'($urandom), $urandom};
      applyStimulus(rndData, SW, 3, 1'b0, "latgs");
      rndData = {16'($urandom), $urandom};
      applyStimulus(rndData, SW, 1, 1'b0, "wrtgs_after_latgs");

      $display("[TB] function control");
      applyStimulus(48'h0000_0000_BEEF, SW, 5, 1'b0, "wrtfc_unarmed");
      applyStimulus(48'h0, 15, 15, 1'b0, "fcwrten");
      applyStimulus(48'h0000_0000_BEEF, SW, 5, 1'b0, "wrtfc_armed");
      applyStimulus(48'h0000_0000_1111, SW, 5, 1'b0, "wrtfc_disarmed");

      $display("[TB] length and command errors");
      rndData = {16'($urandom), $urandom};
      applyStimulus(rndData, 40, 1, 1'b0, "wrtgs_short");
      applyStimulus(48'h0, 7, 7, 1'b0, "cmd7");
      rndData = {16'($urandom), $urandom};
      applyStimulus(rndData, 40, 33, 1'b0, "lat_saturated");

      $display("[TB] reset mid-word");
      for (int k = 0; k < 20; k++)
         shiftBit(1'($urandom_range(1, 0)), 1'b0);
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      #1;
      checkOutput("in_reset", 5'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rndData = {16'($urandom), $urandom};
      applyStimulus(rndData, SW, 1, 1'b0, "wrtgs_post_reset");

      $display("[TB] SCLK rise coincident with LAT fall");
      applyStimulus(48'h3, 2, 2, 1'b1, "coincident");
      rndData = {16'($urandom), $urandom};
      applyStimulus(rndData, 47, 1, 1'b0, "wrtgs_after_coincident");

      $display("[TB] random commands");
      for (int i = 0; i < 16; i++) begin
         latPick = latChoices[$urandom_range(7, 0)];
         bitPick = (latPick == 15) ? 15 + $urandom_range(33, 0) : 44 + $urandom_range(4, 0);
         rndData = {16'($urandom), $urandom};
         applyStimulus(rndData, bitPick, latPick, 1'b0, $sformatf("rnd_%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
